// File: rtl/sq_drain_unit_pkg.sv
// Shared types for the store-queue drain slice: CPU configuration, store queue
// entry layout and the drain state encoding.
package sq_drain_unit_pkg;

  typedef struct packed {
    int unsigned SQ_DEPTH;
  } cpu_config_t;

  localparam cpu_config_t EXAMPLE_CONFIG = '{SQ_DEPTH: 8};

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [2:0]  cache_op;
    logic [31:0] data;
    logic        fp;
    logic        is_double;
    logic [63:0] fp_data;
  } sq_entry_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE     = 2'd0,
    DRAIN_DRAINING = 2'd1,
    DRAIN_DONE     = 2'd2
  } sq_drain_state_t;

endpackage

// File: rtl/sq_drain_unit_request_buffer.sv
// Single-entry holding register between the store queue head and the memory
// write port; refills in the same cycle its current entry is accepted.
module sq_request_buffer
  import sq_drain_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      sq_valid,
  input  sq_entry_t sq_data_out,
  input  logic      accept,
  output logic      sq_pop,
  output logic      buf_valid,
  output sq_entry_t buf_data
);

  logic      buf_valid_reg;
  sq_entry_t buf_data_reg;

  assign sq_pop    = sq_valid & (~buf_valid_reg | accept);
  assign buf_valid = buf_valid_reg;
  assign buf_data  = buf_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_reg <= 1'b0;
    end else if (sq_pop) begin
      buf_valid_reg <= 1'b1;
    end else if (accept) begin
      buf_valid_reg <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while buf_valid_reg is set.
  always_ff @(posedge clk) begin
    if (sq_pop) begin
      buf_data_reg <= sq_data_out;
    end
  end

endmodule

// File: rtl/sq_drain_unit.sv
// Store queue consumer: issues released stores as memory writes, tracks
// unacknowledged writes, arbitrates against loads and reports fence drains.
module sq_drain_unit
  import sq_drain_unit_pkg::*;
#(
  parameter cpu_config_t CONFIG          = EXAMPLE_CONFIG,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      sq_valid,
  input  logic      sq_empty,
  input  sq_entry_t sq_data_out,
  output logic      sq_pop,
  input  logic      load_pending,
  output logic      mem_req_valid,
  input  logic      mem_req_ready,
  output sq_entry_t mem_req,
  input  logic      mem_wr_ack,
  input  logic      drain_request,
  output logic      drain_done
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [OW-1:0] OUT_MAX    = OW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic            buf_valid;
  logic            accept;
  logic            starved;
  logic            headroom;
  logic            drain_active;
  logic [OW-1:0]   outstanding_reg, outstanding_next;
  logic [SW-1:0]   starve_cnt_reg, starve_cnt_next;
  sq_drain_state_t state_reg, state_next;

  sq_request_buffer u_req_buf (
    .clk         (clk),
    .rst         (rst),
    .sq_valid    (sq_valid),
    .sq_data_out (sq_data_out),
    .accept      (accept),
    .sq_pop      (sq_pop),
    .buf_valid   (buf_valid),
    .buf_data    (mem_req)
  );

  // An ack arriving this cycle frees a slot immediately, so a full window
  // does not cost an extra bubble.
  assign headroom      = (outstanding_reg < OUT_MAX) | mem_wr_ack;
  assign starved       = (starve_cnt_reg == STARVE_MAX);
  assign mem_req_valid = buf_valid & headroom & (~load_pending | starved | drain_active);
  assign accept        = mem_req_valid & mem_req_ready;

  always_comb begin
    outstanding_next = outstanding_reg;
    if (accept & ~mem_wr_ack) begin
      outstanding_next = outstanding_reg + OW'(1);
    end else if (~accept & mem_wr_ack) begin
      outstanding_next = outstanding_reg - OW'(1);
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (accept) begin
      starve_cnt_next = '0;
    end else if (buf_valid & load_pending & ~mem_req_valid & ~starved) begin
      starve_cnt_next = starve_cnt_reg + SW'(1);
    end
  end

  always_comb begin
    state_next   = state_reg;
    drain_active = (state_reg == DRAIN_DRAINING);
    drain_done   = (state_reg == DRAIN_DONE);
    unique case (state_reg)
      DRAIN_IDLE:     if (drain_request) state_next = DRAIN_DRAINING;
      DRAIN_DRAINING: if (sq_empty & ~buf_valid & (outstanding_reg == '0)) state_next = DRAIN_DONE;
      DRAIN_DONE:     if (~drain_request) state_next = DRAIN_IDLE;
      default:        state_next = DRAIN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_reg <= '0;
      starve_cnt_reg  <= '0;
      state_reg       <= DRAIN_IDLE;
    end else begin
      outstanding_reg <= outstanding_next;
      starve_cnt_reg  <= starve_cnt_next;
      state_reg       <= state_next;
    end
  end

  a_ack_without_write: assert property (@(posedge clk) disable iff (rst)
    mem_wr_ack |-> (outstanding_reg != '0));

  a_pop_without_valid: assert property (@(posedge clk) disable iff (rst)
    sq_pop |-> sq_valid);

  a_window_bounded: assert property (@(posedge clk) disable iff (rst)
    (outstanding_reg <= OUT_MAX) && (CONFIG.SQ_DEPTH != 0));

endmodule

// File: tb/tb_sq_drain_unit.sv
// Directed bench for sq_drain_unit: a rule-level model is compared on every
// falling edge, plus hand-computed expectations per scenario.
module tb_sq_drain_unit;
  import sq_drain_unit_pkg::*;

  localparam int MAXO = 4;
  localparam int SLIM = 8;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      sq_valid, sq_empty, sq_pop;
  logic      load_pending = 1'b0;
  logic      mem_req_valid;
  logic      mem_req_ready = 1'b0;
  logic      mem_wr_ack;
  logic      drain_request = 1'b0;
  logic      drain_done;
  sq_entry_t sq_data_out, mem_req;

  // Store queue and memory environment
  sq_entry_t entry_mem [64];
  int        head = 0, tail = 0, seq = 0, cyc = 0;
  logic      man_ack = 1'b0, auto_ack_q = 1'b0, auto_ack = 1'b1;
  int        ack_lat = 2;
  int        ack_due[$];
  int        env_outst = 0, peak = 0;
  sq_entry_t exp_q[$];
  logic      pop_s = 1'b0, acc_s = 1'b0, ack_s = 1'b0;
  int        pop_cnt = 0, acc_cnt = 0, last_ack_cyc = -1;
  int        n_checks = 0, n_errors = 0;

  // Behavioural model state
  bit        m_full = 1'b0;
  sq_entry_t m_buf;
  int        m_outst = 0, m_wait = 0, m_phase = 0;

  assign sq_valid    = (head != tail);
  assign sq_empty    = (head == tail);
  assign sq_data_out = entry_mem[head % 64];
  assign mem_wr_ack  = auto_ack_q | man_ack;

  always #5 clk = ~clk;

  sq_drain_unit #(.CONFIG(EXAMPLE_CONFIG), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SLIM)) dut (
    .clk           (clk),
    .rst           (rst),
    .sq_valid      (sq_valid),
    .sq_empty      (sq_empty),
    .sq_data_out   (sq_data_out),
    .sq_pop        (sq_pop),
    .load_pending  (load_pending),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req       (mem_req),
    .mem_wr_ack    (mem_wr_ack),
    .drain_request (drain_request),
    .drain_done    (drain_done)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic sq_entry_t make_entry(input int i);
    sq_entry_t e;
    e.addr      = 32'h1000 + 32'(i) * 4;
    e.be        = 4'hF ^ 4'(i);
    e.cache_op  = 3'(i);
    e.data      = 32'hA500_0000 + 32'(i);
    e.fp        = i[0];
    e.is_double = i[1];
    e.fp_data   = {32'hDEAD_0000 + 32'(i), 32'(i * 3)};
    return e;
  endfunction

  task automatic push_n(input int n);
    for (int k = 0; k < n; k++) begin
      entry_mem[tail % 64] = make_entry(seq);
      exp_q.push_back(make_entry(seq));
      seq++;
      tail++;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Compare against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    bit e_valid, e_acc, e_pop;
    e_valid = m_full && ((m_outst < MAXO) || mem_wr_ack) &&
              (!load_pending || (m_wait >= SLIM) || (m_phase == 1));
    e_acc   = e_valid && mem_req_ready;
    e_pop   = sq_valid && (!m_full || e_acc);
    chk("sq_pop", sq_pop, e_pop);
    chk("mem_req_valid", mem_req_valid, e_valid);
    chk("drain_done", drain_done, m_phase == 2);
    if (e_valid) begin
      n_checks++;
      if (mem_req !== m_buf) begin
        n_errors++;
        $display("FAIL mem_req_payload: got %h expected %h (cycle %0d)", mem_req, m_buf, cyc);
      end
    end
    pop_s = sq_pop;
    acc_s = mem_req_valid & mem_req_ready;
    ack_s = mem_wr_ack;
    if (sq_pop) pop_cnt++;
    if (acc_s) acc_cnt++;
    if (ack_s) last_ack_cyc = cyc;
    if (acc_s && !rst) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL write_order: got unexpected write %h (cycle %0d)", mem_req, cyc);
      end else begin
        if (mem_req !== exp_q[0]) begin
          n_errors++;
          $display("FAIL write_order: got %h expected %h (cycle %0d)", mem_req, exp_q[0], cyc);
        end
        void'(exp_q.pop_front());
      end
    end
    if (rst) begin
      m_full = 1'b0; m_outst = 0; m_wait = 0; m_phase = 0;
    end else begin
      case (m_phase)
        0: if (drain_request) m_phase = 1;
        1: if (sq_empty && !m_full && m_outst == 0) m_phase = 2;
        default: if (!drain_request) m_phase = 0;
      endcase
      if (e_acc) m_wait = 0;
      else if (m_full && load_pending && !e_valid && m_wait < SLIM) m_wait++;
      m_outst = m_outst + (e_acc ? 1 : 0) - (mem_wr_ack ? 1 : 0);
      if (e_pop) begin
        m_buf  = sq_data_out;
        m_full = 1'b1;
      end else if (e_acc) begin
        m_full = 1'b0;
      end
    end
  end

  // Queue pops and memory acks, applied just after the edge that took them.
  always @(posedge clk) begin
    #1;
    cyc++;
    auto_ack_q = 1'b0;
    if (rst) begin
      ack_due.delete();
      env_outst = 0;
    end else begin
      if (pop_s) head++;
      if (ack_s) env_outst--;
      if (acc_s) begin
        env_outst++;
        if (auto_ack) ack_due.push_back(cyc - 1 + ack_lat);
      end
      if (env_outst > peak) peak = env_outst;
      if (ack_due.size() > 0 && ack_due[0] <= cyc) begin
        auto_ack_q = 1'b1;
        void'(ack_due.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, a0, c0, k, done_cyc;
    bit found;

    // Reset
    step(3);
    @(negedge clk);
    chk("reset_sq_pop", sq_pop, 0);
    chk("reset_mem_req_valid", mem_req_valid, 0);
    chk("reset_drain_done", drain_done, 0);
    step(1);
    rst = 1'b0;
    step(2);

    // Back-to-back: four pops on consecutive cycles, acks two cycles later
    mem_req_ready = 1'b1; auto_ack = 1'b1; ack_lat = 2; peak = 0;
    p0 = pop_cnt;
    push_n(4);
    step(4);
    chk("b2b_pops_in_4_cycles", pop_cnt - p0, 4);
    step(8);
    chk("b2b_peak_outstanding", peak, 2);

    // Backpressure: one pop, held request, second pop on acceptance
    mem_req_ready = 1'b0;
    p0 = pop_cnt;
    push_n(2);
    step(5);
    chk("bp_pops_while_stalled", pop_cnt - p0, 1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_valid", mem_req_valid, 1);
    chk("bp_pop_on_accept", sq_pop, 1);
    step(8);

    // Load priority: blocked for STARVE_LIMIT cycles, then issued
    load_pending = 1'b1;
    push_n(1);
    @(negedge clk);
    k = 0; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (mem_req_valid) found = 1'b1;
      else k++;
    end
    chk("starve_release_seen", found, 1);
    chk("starve_blocked_cycles", k, 8);
    step(1);
    load_pending = 1'b0;
    step(6);

    // Outstanding limit: four accepts, then one per ack in the same cycle
    auto_ack = 1'b0;
    a0 = acc_cnt;
    push_n(6);
    step(8);
    chk("limit_accepts", acc_cnt - a0, 4);
    man_ack = 1'b1;
    @(negedge clk);
    chk("limit_ack_same_cycle_valid", mem_req_valid, 1);
    step(1);
    man_ack = 1'b0;
    step(3);
    chk("limit_one_more_accept", acc_cnt - a0, 5);
    for (int i = 0; i < 20; i++) begin
      man_ack = (env_outst > 0);
      step(1);
    end
    man_ack = 1'b0;
    auto_ack = 1'b1;
    chk("limit_all_accepted", acc_cnt - a0, 6);
    step(4);

    // Drain with three stores queued
    c0 = cyc;
    push_n(3);
    drain_request = 1'b1;
    done_cyc = -1;
    for (int i = 0; i < 40 && done_cyc < 0; i++) begin
      @(negedge clk);
      if (drain_done) done_cyc = cyc;
    end
    chk("drain_done_seen", done_cyc >= 0, 1);
    chk("drain_done_after_last_ack", done_cyc - last_ack_cyc, 2);
    chk("drain_done_cycle", done_cyc - c0, 7);
    step(1);
    drain_request = 1'b0;
    @(negedge clk);
    chk("drain_done_held", drain_done, 1);
    step(1);
    @(negedge clk);
    chk("drain_done_cleared", drain_done, 0);
    step(2);

    // Drain with an empty queue
    drain_request = 1'b1;
    @(negedge clk);
    chk("empty_drain_plus0", drain_done, 0);
    step(1);
    @(negedge clk);
    chk("empty_drain_plus1", drain_done, 0);
    step(1);
    @(negedge clk);
    chk("empty_drain_plus2", drain_done, 1);
    step(1);
    drain_request = 1'b0;
    step(3);

    // Reset with two writes outstanding
    auto_ack = 1'b0;
    push_n(2);
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_sq_pop", sq_pop, 0);
    chk("midreset_mem_req_valid", mem_req_valid, 0);
    chk("midreset_drain_done", drain_done, 0);
    step(1);
    drain_request = 1'b1;
    auto_ack = 1'b1;
    step(1);
    @(negedge clk);
    chk("post_reset_drain_plus1", drain_done, 0);
    step(1);
    @(negedge clk);
    chk("post_reset_drain_plus2", drain_done, 1);
    step(1);
    drain_request = 1'b0;
    step(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
